// File: rtl/imem_load_arbiter_if.sv
// rtl/imem_load_arbiter_if.sv - byte stream and instruction-memory port bundle for imem_load_arbiter
interface imem_load_arbiter_if #(
    parameter int ADDR_W = 14
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_we;

    modport master (
        input  byte_valid,
        input  byte_data,
        output mem_addr,
        output mem_wdata,
        output mem_we
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  mem_addr,
        input  mem_wdata,
        input  mem_we
    );
endinterface

// File: rtl/imem_load_arbiter.sv
// rtl/imem_load_arbiter.sv - instruction-memory port arbiter between fetch and UART program loader
// Optional idle-byte timeout inside a partial word: define IMEM_LOAD_TIMEOUT_EN.
module imem_load_arbiter #(
    parameter int ADDR_W         = 14,
    parameter int DEPTH          = 16384,
    parameter int DRAIN_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load_req,
    input  logic [ADDR_W-1:0] i_fetch_addr,
    imem_load_arbiter_if.master bus,
    output logic              o_fetch_stall,
    output logic              o_core_hold,
    output logic              o_load_done,
    output logic [ADDR_W:0]   o_word_count,
    output logic              o_err_overflow,
    output logic              o_err_partial,
    output logic              o_err_timeout
);
    localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [ADDR_W:0]  DEPTH_P  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_LOAD,
        S_WRITE,
        S_RELEASE
    } state_t;

    state_t           r_state;
    logic [DRN_W-1:0] r_drain_cnt;
    logic [ADDR_W:0]  r_wr_ptr;
    logic [1:0]       r_byte_idx;
    logic [31:0]      r_buf;
    logic [3:0]       r_mem_we;
    logic             r_load_done;
    logic             r_err_ovf;
    logic             r_err_part;
    logic             w_room;

`ifdef IMEM_LOAD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_err_to;
    assign o_err_timeout = r_err_to;
`else
    assign o_err_timeout = 1'b0;
`endif

    // The pointer never wraps, so it doubles as the session word count.
    assign w_room = (r_wr_ptr < DEPTH_P);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= '0;
            r_wr_ptr    <= '0;
            r_byte_idx  <= '0;
            r_buf       <= '0;
            r_mem_we    <= '0;
            r_load_done <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_err_part  <= 1'b0;
`ifdef IMEM_LOAD_TIMEOUT_EN
            r_tmo_cnt   <= '0;
            r_err_to    <= 1'b0;
`endif
        end else begin
            r_mem_we    <= '0;
            r_load_done <= 1'b0;
`ifdef IMEM_LOAD_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (i_load_req) begin
                        r_state     <= S_DRAIN;
                        r_drain_cnt <= DRN_LOAD;
                        r_wr_ptr    <= '0;
                        r_byte_idx  <= '0;
                        r_err_ovf   <= 1'b0;
                        r_err_part  <= 1'b0;
`ifdef IMEM_LOAD_TIMEOUT_EN
                        r_err_to    <= 1'b0;
`endif
                    end
                end
                S_DRAIN: begin
                    if (!i_load_req) begin
                        r_state     <= S_RELEASE;
                        r_load_done <= 1'b1;
                    end else if (r_drain_cnt == '0) begin
                        r_state <= S_LOAD;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                    end
                end
                S_LOAD: begin
                    if (bus.byte_valid) begin
                        r_buf[{r_byte_idx, 3'b000} +: 8] <= bus.byte_data;
                        if (r_byte_idx == 2'd3) begin
                            r_byte_idx <= '0;
                            r_state    <= S_WRITE;
                            r_mem_we   <= w_room ? 4'b1111 : 4'b0000;
                        end else begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                        end
                    end else if (!i_load_req) begin
                        if (r_byte_idx != '0) begin
                            r_err_part <= 1'b1;
                        end
                        r_byte_idx  <= '0;
                        r_state     <= S_RELEASE;
                        r_load_done <= 1'b1;
                    end
`ifdef IMEM_LOAD_TIMEOUT_EN
                    else if (r_byte_idx != '0) begin
                        if (r_tmo_cnt == TMO_LAST) begin
                            r_byte_idx <= '0;
                            r_err_to   <= 1'b1;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        end
                    end
`endif
                end
                S_WRITE: begin
                    if (w_room) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end else begin
                        r_err_ovf <= 1'b1;
                    end
                    // A byte landing during the write starts the next word.
                    if (bus.byte_valid) begin
                        r_buf[7:0] <= bus.byte_data;
                        r_byte_idx <= 2'd1;
                    end
                    r_state <= S_LOAD;
                end
                S_RELEASE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr   = (r_state == S_IDLE) ? i_fetch_addr : r_wr_ptr[ADDR_W-1:0];
    assign bus.mem_wdata  = r_buf;
    assign bus.mem_we     = r_mem_we;
    assign o_fetch_stall  = (r_state != S_IDLE);
    assign o_core_hold    = (r_state != S_IDLE);
    assign o_load_done    = r_load_done;
    assign o_word_count   = r_wr_ptr;
    assign o_err_overflow = r_err_ovf;
    assign o_err_partial  = r_err_part;
endmodule

// File: tb/tb_imem_load_arbiter.sv
// tb/tb_imem_load_arbiter.sv - self-checking bench for imem_load_arbiter with behavioural session model
module tb_imem_load_arbiter;
    localparam int AW    = 6;
    localparam int DEPTH = 6;
    localparam int DRAIN = 4;

    localparam int M_IDLE  = 0;
    localparam int M_DRAIN = 1;
    localparam int M_LOAD  = 2;
    localparam int M_WRITE = 3;
    localparam int M_REL   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_stall, core_hold, load_done;
    logic [AW:0]   word_count;
    logic          err_overflow, err_partial, err_timeout;

    imem_load_arbiter_if #(.ADDR_W(AW)) bus ();

    imem_load_arbiter #(
        .ADDR_W(AW), .DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .rst(rst), .i_load_req(load_req), .i_fetch_addr(fetch_addr),
        .bus(bus),
        .o_fetch_stall(fetch_stall), .o_core_hold(core_hold), .o_load_done(load_done),
        .o_word_count(word_count), .o_err_overflow(err_overflow),
        .o_err_partial(err_partial), .o_err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: session phase, bytes of the word being assembled,
    // words accepted so far, and the raw log of every accepted byte.
    int         m_mode = M_IDLE;
    int         m_drain_left = 0;
    int         m_wcnt = 0;
    bit         m_ovf = 0, m_part = 0;
    logic [7:0] m_q[$];
    logic [7:0] m_log[$];
    logic [31:0] dut_mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (rst) begin
            m_mode = M_IDLE; m_wcnt = 0; m_ovf = 0; m_part = 0;
            m_q.delete(); m_log.delete();
        end else begin
            if ((m_mode == M_LOAD || m_mode == M_WRITE) && bus.byte_valid)
                m_log.push_back(bus.byte_data);
            case (m_mode)
                M_IDLE: if (load_req) begin
                    m_mode = M_DRAIN; m_drain_left = DRAIN; m_wcnt = 0;
                    m_ovf = 0; m_part = 0; m_q.delete(); m_log.delete();
                end
                M_DRAIN: begin
                    if (!load_req) m_mode = M_REL;
                    else if (m_drain_left == 1) m_mode = M_LOAD;
                    else m_drain_left--;
                end
                M_LOAD: begin
                    if (bus.byte_valid) begin
                        m_q.push_back(bus.byte_data);
                        if (m_q.size() == 4) m_mode = M_WRITE;
                    end else if (!load_req) begin
                        if (m_q.size() != 0) m_part = 1;
                        m_q.delete();
                        m_mode = M_REL;
                    end
                end
                M_WRITE: begin
                    if (m_wcnt < DEPTH) m_wcnt++;
                    else m_ovf = 1;
                    m_q.delete();
                    if (bus.byte_valid) m_q.push_back(bus.byte_data);
                    m_mode = M_LOAD;
                end
                default: m_mode = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [AW-1:0] exp_addr;
        logic [3:0]    exp_we;
        int n, nw;
        if (cmp_en) begin
            exp_addr = (m_mode == M_IDLE) ? fetch_addr : AW'(m_wcnt);
            exp_we   = (m_mode == M_WRITE && m_wcnt < DEPTH) ? 4'hF : 4'h0;
            chk("mem_addr", bus.mem_addr, exp_addr);
            chk("mem_we", bus.mem_we, exp_we);
            if (exp_we != 0)
                chk("mem_wdata", bus.mem_wdata, {m_q[3], m_q[2], m_q[1], m_q[0]});
            chk("fetch_stall", fetch_stall, m_mode != M_IDLE);
            chk("core_hold", core_hold, m_mode != M_IDLE);
            chk("load_done", load_done, m_mode == M_REL);
            chk("word_count", word_count, m_wcnt);
            chk("err_overflow", err_overflow, m_ovf);
            chk("err_partial", err_partial, m_part);
            chk("err_timeout", err_timeout, 0);
            if (bus.mem_we == 4'hF) dut_mem[bus.mem_addr] = bus.mem_wdata;
            if (m_mode == M_REL) begin
                // Session image derived purely from the accepted byte log.
                n  = m_log.size();
                nw = (n / 4 < DEPTH) ? n / 4 : DEPTH;
                chk("img_words", word_count, nw);
                chk("img_partial", err_partial, (n % 4) != 0);
                chk("img_overflow", err_overflow, (n / 4) > DEPTH);
                for (int i = 0; i < nw; i++)
                    chk("img_data", dut_mem[i],
                        {m_log[4*i+3], m_log[4*i+2], m_log[4*i+1], m_log[4*i]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.byte_data  = b;
        bus.byte_valid = 1'b1;
        tick();
    endtask

    logic [7:0] seq [0:9];
    int seen, ncyc, p;

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        fetch_addr     = 6'h10;
        @(posedge clk);
        cmp_en = 1'b1;
        #1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_mem_addr", bus.mem_addr, 6'h10);
        chk("reset_stall", {fetch_stall, core_hold}, 2'b00);
        chk("reset_we", bus.mem_we, 4'h0);
        chk("reset_flags", {err_overflow, err_partial, err_timeout, load_done}, 4'h0);
        chk("reset_count", word_count, 0);

        load_req = 1'b1;
        tick();
        @(negedge clk);
        chk("stall_after_req", fetch_stall, 1'b1);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hAA;
        repeat (DRAIN) tick();
        @(negedge clk);
        chk("drain_count", word_count, 0);
        send(8'h13); send(8'h05); send(8'h10); send(8'h00);
        bus.byte_valid = 1'b0;
        @(negedge clk);
        chk("w0_we", bus.mem_we, 4'hF);
        chk("w0_addr", bus.mem_addr, 6'h00);
        chk("w0_data", bus.mem_wdata, 32'h00100513);
        tick();
        @(negedge clk);
        chk("w0_count", word_count, 1);

        seq = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00, 8'hEF, 8'hBE};
        for (int i = 0; i < 10; i++) send(seq[i]);
        bus.byte_valid = 1'b0;
        load_req = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            @(negedge clk);
            if (load_done) seen = 1;
        end
        chk("done_seen", seen, 1);
        @(negedge clk);
        chk("after_rel_stall", fetch_stall, 1'b0);
        chk("after_rel_done", load_done, 1'b0);
        chk("after_rel_partial", err_partial, 1'b1);
        chk("after_rel_count", word_count, 3);
        chk("w1_data", dut_mem[1], 32'h00100093);
        chk("w2_data", dut_mem[2], 32'h00200113);

        for (int s = 0; s < 40; s++) begin
            load_req = 1'b1;
            ncyc = $urandom_range(0, 80);
            p    = $urandom_range(20, 100);
            for (int c = 0; c < ncyc; c++) begin
                bus.byte_valid = ($urandom_range(0, 99) < p);
                bus.byte_data  = 8'($urandom);
                tick();
            end
            if ($urandom_range(0, 5) == 0) begin
                rst = 1'b1; load_req = 1'b0; bus.byte_valid = 1'b0;
                tick();
                rst = 1'b0;
                @(negedge clk);
                chk("rst_count", word_count, 0);
                chk("rst_stall", fetch_stall, 1'b0);
                chk("rst_done", load_done, 1'b0);
            end else begin
                load_req = 1'b0;
                repeat (2) begin
                    bus.byte_valid = ($urandom_range(0, 1) == 1);
                    bus.byte_data  = 8'($urandom);
                    tick();
                end
                bus.byte_valid = 1'b0;
                seen = 0;
                for (int k = 0; k < 30 && seen == 0; k++) begin
                    @(negedge clk);
                    if (!fetch_stall) seen = 1;
                end
                chk("session_end", seen, 1);
            end
            repeat ($urandom_range(1, 3)) begin
                fetch_addr = AW'($urandom);
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_load_arbiter.md
Name: imem_load_arbiter

Overview:
- Sequences and owns the single port of the instruction memory (prgrom).
- Shares the port between the fetch stage (reads) and the UART program loader (byte stream).
- On a load request: drains and holds the core, assembles little-endian 32-bit words from received bytes, writes them to consecutive word addresses, then returns the port to fetch and pulses load_done.

Parameters:
- ADDR_W, 14, word-address width of instruction memory.
- DEPTH, 16384, number of writable words; must be <= 2**ADDR_W.
- DRAIN_CYCLES, 4, cycles the core is stalled before the first write (pipeline drain).
- TIMEOUT_CYCLES, 1000000, idle-byte timeout inside a partial word (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- load_req  in  1  level; high = program-load mode requested.
- byte_valid  in  1  one-cycle strobe; byte_data valid.
- byte_data  in  8  received UART byte.
- fetch_addr  in  ADDR_W  word address requested by fetch (pc[ADDR_W+1:2]).
- mem_addr  out  ADDR_W  address to instruction memory.
- mem_wdata  out  32  write data to instruction memory.
- mem_we  out  4  byte write enables (all-ones or zero).
- fetch_stall  out  1  fetch must hold pc and inject NOP.
- core_hold  out  1  hold the rest of the core (pipeline freeze).
- load_done  out  1  one-cycle pulse after a load session ends.
- word_count  out  ADDR_W+1  words written in the current/last session.
- err_overflow  out  1  sticky; a word arrived with the write pointer == DEPTH.
- err_partial  out  1  sticky; session ended with 1-3 buffered bytes.
- err_timeout  out  1  sticky; optional-feature timeout fired (0 when the feature is compiled out).

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; wr_ptr, byte_idx, drain counter, word buffer, word_count=0; mem_we=0; load_done=0; all err flags=0.
- mem_addr: = fetch_addr in IDLE (combinational mux, zero added latency); = wr_ptr otherwise.
- fetch_stall and core_hold: = (state != IDLE), combinational.
- IDLE: mem_we=0. If load_req=1, go to DRAIN; load drain counter with DRAIN_CYCLES-1; clear wr_ptr, byte_idx, word_count and all err flags.
- DRAIN: decrement the counter; ignore bytes. At 0, go to LOAD. If load_req drops during DRAIN, go to RELEASE (zero words written).
- LOAD, on byte_valid:
  - buffer[8*byte_idx +: 8] <= byte_data; byte_idx++.
  - On the 4th byte (byte_idx==3), go to WRITE, byte_idx <= 0.
- LOAD, load_req=0 and no byte in the same cycle: if byte_idx != 0, set err_partial and discard the buffer. Then go to RELEASE.
- LOAD, byte_valid and load_req=0 in the same cycle: the byte is accepted first; the end of session is evaluated the next cycle.
- WRITE (exactly 1 cycle):
  - If wr_ptr < DEPTH: mem_we=4'b1111, mem_wdata=buffer, then wr_ptr++ and word_count++.
  - Else: mem_we=0, set err_overflow, and the word is dropped.
  - byte_valid in WRITE is accepted into buffer byte 0 (byte_idx <= 1), so back-to-back bytes are never lost.
  - Next state is LOAD.
- RELEASE (1 cycle): load_done=1; next state IDLE. fetch resumes the following cycle with the port returned.
- Word assembly is little-endian: first byte -> bits[7:0].
- wr_ptr is ADDR_W+1 bits wide and never wraps; it saturates at DEPTH.
- rst asserted mid-session: immediate return to IDLE with all state cleared. Words already written stay in memory; no load_done pulse.
- mem_wdata is held at buffer in every state; it is only meaningful while mem_we != 0.

Optional Feature:
- Macro: IMEM_LOAD_TIMEOUT_EN.
- Defined: in LOAD with byte_idx != 0, a counter counts cycles since the last byte_valid. When it reaches TIMEOUT_CYCLES: discard the partial word, set byte_idx=0, set err_timeout (sticky), and stay in LOAD. The counter resets on every byte_valid and on leaving LOAD.
- Not defined: no counter is built; err_timeout is tied to 0 and partial words wait indefinitely.

Test Plan:
- Reset, then fetch_addr=0x0010 in IDLE -> mem_addr=0x0010 the same cycle; mem_we=0, fetch_stall=0, core_hold=0, all flags 0.
- load_req=1 -> fetch_stall=1 the next cycle; bytes sent during the 4 DRAIN cycles are ignored; word_count stays 0.
- After the drain, bytes 0x13,0x05,0x10,0x00 -> one WRITE cycle: mem_we=4'hF, mem_addr=0, mem_wdata=0x00100513, word_count=1.
- Back-to-back bytes (strobe every cycle) for 3 words -> writes to addr 0,1,2 with correct data; no byte lost at WRITE; word_count=3.
- Send 6 bytes, then load_req=0 -> 1 word written, err_partial=1, load_done pulses once, state IDLE, fetch_stall=0 the cycle after RELEASE.
- DEPTH=2 build, send 12 bytes -> writes to addr 0,1 only; err_overflow=1; word_count=2.
- With IMEM_LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=50: send 2 bytes, wait 50 cycles -> err_timeout=1; the next 4 bytes form a complete word at addr 0.
- Assert rst mid-word -> state IDLE, word_count=0, no load_done pulse.
